// File: rtl/apb_arbiter.sv
// Two-requester round-robin arbiter driving a single APB master port.
// Each requester's transfer is latched at grant and run through SETUP/ACCESS.
// A wait-state counter aborts a stalled ACCESS and reports it with an error pulse.
module apb_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        REQ0,
  input  logic        REQ1,
  input  logic        WRITE0,
  input  logic        WRITE1,
  input  logic [31:0] ADDR0,
  input  logic [31:0] ADDR1,
  input  logic [31:0] WDATA0,
  input  logic [31:0] WDATA1,
  output logic        GNT0,
  output logic        GNT1,
  output logic        DONE0,
  output logic        DONE1,
  output logic        ERR0,
  output logic        ERR1,
  output logic [31:0] RDATA0,
  output logic [31:0] RDATA1,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  input  logic        PREADY,
  input  logic [31:0] PRDATA
);

  // Counter must represent TIMEOUT itself without wrapping.
  localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cnt_inc;
  logic               pick1;
  logic               owner;
  logic               finish;

  logic               gnt0_d, gnt1_d, done0_d, done1_d, err0_d, err1_d;
  logic               psel_d, penable_d, pwrite_d;
  logic [31:0]        paddr_d, pwdata_d, rdata0_d, rdata1_d;

  // State, pointer, counter and all registered outputs.
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      GNT0    <= 1'b0;
      GNT1    <= 1'b0;
      DONE0   <= 1'b0;
      DONE1   <= 1'b0;
      ERR0    <= 1'b0;
      ERR1    <= 1'b0;
      RDATA0  <= 32'd0;
      RDATA1  <= 32'd0;
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
      PADDR   <= 32'd0;
      PWDATA  <= 32'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      GNT0    <= gnt0_d;
      GNT1    <= gnt1_d;
      DONE0   <= done0_d;
      DONE1   <= done1_d;
      ERR0    <= err0_d;
      ERR1    <= err1_d;
      RDATA0  <= rdata0_d;
      RDATA1  <= rdata1_d;
      PSEL    <= psel_d;
      PENABLE <= penable_d;
      PWRITE  <= pwrite_d;
      PADDR   <= paddr_d;
      PWDATA  <= pwdata_d;
    end
  end

  // Next-state, arbitration and next values of the registered outputs.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    cnt_inc   = cnt_q + CNT_W'(1);
    pick1     = 1'b0;
    owner     = GNT1;
    finish    = 1'b0;
    gnt0_d    = GNT0;
    gnt1_d    = GNT1;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    err0_d    = 1'b0;
    err1_d    = 1'b0;
    rdata0_d  = RDATA0;
    rdata1_d  = RDATA1;
    psel_d    = PSEL;
    penable_d = PENABLE;
    pwrite_d  = PWRITE;
    paddr_d   = PADDR;
    pwdata_d  = PWDATA;

    case (state_q)
      IDLE: begin
        if (REQ0 || REQ1) begin
          // On a tie, the requester not served last wins.
          pick1     = (REQ0 && REQ1) ? ~last_q : REQ1;
          state_d   = SETUP;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          gnt0_d    = ~pick1;
          gnt1_d    = pick1;
          pwrite_d  = pick1 ? WRITE1 : WRITE0;
          paddr_d   = pick1 ? ADDR1  : ADDR0;
          pwdata_d  = pick1 ? WDATA1 : WDATA0;
        end
      end

      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end

      ACCESS: begin
        finish = PREADY || (cnt_inc == CNT_W'(TIMEOUT));
        if (finish) begin
          state_d   = IDLE;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          gnt0_d    = 1'b0;
          gnt1_d    = 1'b0;
          last_d    = owner;
          done0_d   = ~owner;
          done1_d   = owner;
          err0_d    = ~owner & ~PREADY;
          err1_d    = owner & ~PREADY;
          // Only a real read completion updates the captured data.
          if (PREADY && !PWRITE) begin
            if (owner) rdata1_d = PRDATA;
            else       rdata0_d = PRDATA;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: doc/apb_arbiter.md
APB_ARBITER -- requirements
Module: apb_arbiter

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
  TIMEOUT  16  maximum ACCESS-phase cycles to wait for PREADY before abort
REQ-002 The block SHALL have these ports, one per line: name  direction  width  meaning.
  PCLK  in  1  single clock; all logic on rising edge
  PRESET  in  1  reset, asynchronous, active-low
  REQ0 / REQ1  in  1  transfer request, requester 0 / 1
  WRITE0 / WRITE1  in  1  1 = write, 0 = read
  ADDR0 / ADDR1  in  32  transfer address
  WDATA0 / WDATA1  in  32  write data
  GNT0 / GNT1  out  1  requester owns the bus, registered
  DONE0 / DONE1  out  1  one-cycle completion pulse, registered
  ERR0 / ERR1  out  1  one-cycle timeout pulse, coincident with DONE, registered
  RDATA0 / RDATA1  out  32  captured read data, registered
  PSEL  out  1  APB select
  PENABLE  out  1  APB enable
  PWRITE  out  1  APB direction
  PADDR  out  32  APB address
  PWDATA  out  32  APB write data
  PREADY  in  1  slave ready
  PRDATA  in  32  slave read data
REQ-003 Reset SHALL be asynchronous and active-low on PRESET; PCLK SHALL be the only clock.

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, SETUP, ACCESS.
REQ-005 IDLE: if REQ0 or REQ1 is high at the edge, the block SHALL choose a winner, latch its WRITE/ADDR/WDATA into PWRITE/PADDR/PWDATA, assert GNTn, set PSEL=1, PENABLE=0, and go to SETUP.
REQ-006 Arbitration SHALL be round-robin: on a single request, that requester wins; on simultaneous requests, the requester not served last wins. The last-served pointer SHALL reset to 1, so requester 0 wins the first tie.
REQ-007 SETUP SHALL last exactly one cycle and then go to ACCESS with PENABLE=1; PSEL, PADDR, PWRITE and PWDATA SHALL remain stable.
REQ-008 ACCESS: if PREADY is high at the edge, the block SHALL set PSEL=0, PENABLE=0 and GNTn=0, pulse DONEn for one cycle, update the last-served pointer, and return to IDLE.
REQ-009 On a read completion, RDATAn SHALL load PRDATA at the PREADY edge; on a write completion, RDATAn SHALL hold.
REQ-010 A wait counter SHALL clear on entry to ACCESS and increment on each ACCESS cycle with PREADY low.
REQ-011 If the counter reaches TIMEOUT with PREADY still low, the block SHALL abort exactly as REQ-008, but SHALL also pulse ERRn and leave RDATAn unchanged.
REQ-012 Request inputs SHALL be ignored outside IDLE; changing ADDRn, WDATAn or WRITEn after grant SHALL have no effect on the transfer.
REQ-013 A request still high in the cycle of its DONE SHALL be treated as a new request in the following IDLE, subject to round-robin.
REQ-014 Minimum transfer latency SHALL be 3 edges from request sampled to DONE high: grant/SETUP, ACCESS, then PREADY edge. Every transfer SHALL include at least one IDLE cycle between transfers.
REQ-015 PSEL=1 with PENABLE=1 SHALL never occur except in ACCESS; GNT0 and GNT1 SHALL never both be high.
REQ-016 The TIMEOUT counter SHALL be wide enough to hold TIMEOUT without wrap.

Reset
REQ-017 While PRESET=0, the block SHALL force state IDLE and the last-served pointer to 1.
REQ-018 While PRESET=0, all outputs SHALL be 0: PSEL, PENABLE, PWRITE, PADDR, PWDATA, GNTn, DONEn, ERRn, RDATAn.
REQ-019 Reset asserted mid-transfer SHALL abort the transfer immediately with no DONE or ERR; after release, the block SHALL start from IDLE.

Verification
REQ-020 Write: REQ0=1, WRITE0=1, ADDR0=0x4, WDATA0=0xA5, PREADY held high -> PSEL rises on edge 1, PENABLE on edge 2, DONE0 is a one-cycle pulse after edge 3, PADDR=0x4, PWDATA=0xA5.
REQ-021 Read with wait states: REQ1 read ADDR1=0x8, PREADY low for 3 ACCESS cycles, then high with PRDATA=0x1234 -> RDATA1=0x1234, DONE1 one pulse, ERR1=0.
REQ-022 Contention: REQ0 and REQ1 held high continuously, PREADY=1 -> grants alternate 0,1,0,1, each transfer is separated by one IDLE cycle, and GNT0/GNT1 never overlap.
REQ-023 Timeout: REQ0 read, PREADY held low -> after 16 ACCESS cycles, DONE0 and ERR0 pulse together, RDATA0 keeps its old value, and the bus returns to idle.
REQ-024 Reset mid-ACCESS: PRESET=0 asynchronously -> all outputs are 0 immediately with no DONE; after release, REQ1 is served first only if REQ0 is low.
REQ-025 Stability: ADDR0 changed during SETUP/ACCESS -> PADDR keeps the latched value until DONE.
